// File: rtl/pc_unit.sv
// pc_unit: RISC-V fetch-stage program counter with trap/redirect/stall priority,
// halt/resume control and misaligned-target rejection. Optional macro: PC_UNIT_C_EXT_EN.
module pc_unit #(
   parameter int          DATA_WIDTH   = 32,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter bit          START_HALTED = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_target,
   input  logic                  redirect_is_jalr,
   input  logic                  trap,
   input  logic [DATA_WIDTH-1:0] trap_vector,
   input  logic                  halt_req,
   input  logic                  resume,
   input  logic                  fetch_ready,
`ifdef PC_UNIT_C_EXT_EN
   input  logic                  inst_is_compressed,
`endif
   output logic [DATA_WIDTH-1:0] pc,
   output logic [DATA_WIDTH-1:0] pc_plus_inc,
   output logic                  pc_valid,
   output logic                  misaligned,
   output logic [DATA_WIDTH-1:0] misaligned_addr,
   output logic                  halted
);
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   state_t                r_state, w_state_next;
   logic [DATA_WIDTH-1:0] r_pc, w_pc_next, w_inc, w_target, w_trap_pc;
   logic [DATA_WIDTH-1:0] r_mis_addr;
   logic                  r_mis, w_mis_t, w_reject;
   logic                  w_unused;
   assign w_unused  = &{1'b0, trap_vector[1:0]};
   assign w_target  = redirect_is_jalr ? {redirect_target[DATA_WIDTH-1:1], 1'b0} : redirect_target;
   assign w_trap_pc = {trap_vector[DATA_WIDTH-1:2], 2'b00};
`ifdef PC_UNIT_C_EXT_EN
   assign w_inc   = inst_is_compressed ? DATA_WIDTH'(2) : DATA_WIDTH'(4);
   assign w_mis_t = w_target[0];
`else
   assign w_inc   = DATA_WIDTH'(4);
   assign w_mis_t = |w_target[1:0];
`endif
   assign pc_plus_inc = r_pc + w_inc;
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_reject     = 1'b0;
      case (r_state)
         BOOT: w_state_next = START_HALTED ? HALT : RUN;
         RUN: begin
            if (halt_req) w_state_next = HALT;
            if (trap) w_pc_next = w_trap_pc;
            else if (redirect_valid) begin
               if (w_mis_t) w_reject = 1'b1;
               else w_pc_next = w_target;
            end else if (!stall && fetch_ready) w_pc_next = pc_plus_inc;
         end
         HALT: begin
            // halt_req outranks resume so a pending debug halt is never lost
            if (!halt_req && resume) w_state_next = RUN;
            if (trap) w_pc_next = w_trap_pc;
         end
         default: w_state_next = BOOT;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= BOOT;
         r_pc       <= DATA_WIDTH'(RESET_VECTOR);
         r_mis      <= 1'b0;
         r_mis_addr <= '0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_mis   <= w_reject;
         if (w_reject) r_mis_addr <= w_target;
      end
   end
   assign pc              = r_pc;
   assign pc_valid        = r_state == RUN;
   assign halted          = r_state == HALT;
   assign misaligned      = r_mis;
   assign misaligned_addr = r_mis_addr;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit sequencing, priority, halt, misalignment and async reset.
module tb_pc_unit;
   logic        clk = 0, rst = 1;
   logic        stall = 0, redirect_valid = 0, redirect_is_jalr = 0, trap = 0;
   logic        halt_req = 0, resume = 0, fetch_ready = 1;
   logic [31:0] redirect_target = 0, trap_vector = 0;
   logic [31:0] pc, pc_plus_inc, misaligned_addr;
   logic        pc_valid, misaligned, halted;
   int          n_checks = 0, n_fail = 0;
`ifdef PC_UNIT_C_EXT_EN
   logic        inst_is_compressed = 0;
   localparam logic [31:0] BAD_T = 32'h1003;
`else
   localparam logic [31:0] BAD_T = 32'h1002;
`endif

   pc_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_target(redirect_target), .redirect_is_jalr(redirect_is_jalr),
      .trap(trap), .trap_vector(trap_vector), .halt_req(halt_req), .resume(resume),
      .fetch_ready(fetch_ready),
`ifdef PC_UNIT_C_EXT_EN
      .inst_is_compressed(inst_is_compressed),
`endif
      .pc(pc), .pc_plus_inc(pc_plus_inc), .pc_valid(pc_valid), .misaligned(misaligned),
      .misaligned_addr(misaligned_addr), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redir(input logic [31:0] t, input logic jalr);
      redirect_valid = 1; redirect_target = t; redirect_is_jalr = jalr;
      tick();
      redirect_valid = 0; redirect_is_jalr = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      tick(); tick();
      chk("rst_pc", pc, 0);
      chk("rst_valid", {31'b0, pc_valid}, 0);
      chk("rst_halted", {31'b0, halted}, 0);
      chk("rst_mis", {31'b0, misaligned}, 0);
      rst = 0;
      tick();
      chk("boot_pc", pc, 0);
      chk("run_valid", {31'b0, pc_valid}, 1);
      chk("pc_plus_inc", pc_plus_inc, 4);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("seq_pc", pc, 32'(4 * i));
      end
      stall = 1;
      for (int i = 0; i < 3; i++) begin tick(); chk("stall_hold", pc, 32'h10); end
      stall = 0; fetch_ready = 0;
      for (int i = 0; i < 2; i++) begin tick(); chk("ready_hold", pc, 32'h10); end
      fetch_ready = 1;
      tick(); chk("after_hold", pc, 32'h14);
      stall = 1;
      redir(32'h200, 0);
      stall = 0;
      chk("redir_over_stall", pc, 32'h200);
      trap = 1; trap_vector = 32'h8000_0103;
      redir(32'h300, 0);
      trap = 0;
      chk("trap_over_redir", pc, 32'h8000_0100);
      redir(32'h1001, 1);
      chk("jalr_clear", pc, 32'h1000);
      chk("jalr_no_pulse", {31'b0, misaligned}, 0);
      redir(BAD_T, 0);
      chk("mis_hold", pc, 32'h1000);
      chk("mis_pulse", {31'b0, misaligned}, 1);
      chk("mis_addr", misaligned_addr, BAD_T);
      redir(32'h1007, 0);
      chk("mis_b2b_pulse", {31'b0, misaligned}, 1);
      chk("mis_b2b_addr", misaligned_addr, 32'h1007);
      tick();
      chk("mis_end", {31'b0, misaligned}, 0);
      chk("mis_addr_held", misaligned_addr, 32'h1007);
      chk("mis_then_inc", pc, 32'h1004);
      redir(32'hFFFF_FFFC, 0);
      chk("pre_wrap", pc, 32'hFFFF_FFFC);
      halt_req = 1;
      tick();
      halt_req = 0;
      chk("wrap", pc, 0);
      chk("halt_flag", {31'b0, halted}, 1);
      chk("halt_valid", {31'b0, pc_valid}, 0);
      for (int i = 0; i < 5; i++) begin tick(); chk("halt_frozen", pc, 0); end
      halt_req = 1; resume = 1;
      tick();
      halt_req = 0;
      chk("halt_wins", {31'b0, halted}, 1);
      tick();
      resume = 0;
      chk("resumed", {31'b0, pc_valid}, 1);
      chk("resume_pc", pc, 0);
      tick(); chk("resume_inc", pc, 4);
      halt_req = 1;
      tick();
      halt_req = 0;
      chk("halt2_pc", pc, 8);
      trap = 1; trap_vector = 32'h103;
      tick();
      trap = 0;
      chk("halt_trap_pc", pc, 32'h100);
      chk("halt_trap_stay", {31'b0, halted}, 1);
      resume = 1;
      tick();
      resume = 0;
      tick(); chk("post_trap_inc", pc, 32'h104);
      redir(32'h40, 0);
      redir(32'h41, 0);
      chk("pre_rst_pc", pc, 32'h40);
      chk("pre_rst_mis", {31'b0, misaligned}, 1);
      #2 rst = 1;
      #1;
      chk("async_pc", pc, 0);
      chk("async_mis", {31'b0, misaligned}, 0);
      chk("async_mis_addr", misaligned_addr, 0);
      chk("async_valid", {31'b0, pc_valid}, 0);
`ifdef PC_UNIT_C_EXT_EN
      tick(); rst = 0;
      tick();
      inst_is_compressed = 1; tick(); chk("c_inc2", pc, 2);
      inst_is_compressed = 0; tick(); chk("c_inc4", pc, 6);
      inst_is_compressed = 1; tick(); chk("c_inc2b", pc, 8);
      inst_is_compressed = 0;
      redir(32'h1002, 0);
      chk("c_half_ok", pc, 32'h1002);
      chk("c_no_pulse", {31'b0, misaligned}, 0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the RISC-V fetch stage; replaces the plain PC counter.
- Holds the PC and selects the next PC, in priority order: trap vector, branch/jump redirect, stall hold, sequential increment.
- Adds halt/resume control, a fetch handshake and misaligned-target detection.
- Sits between the hazard/branch logic and the instruction memory.

Parameters:
- DATA_WIDTH, 32: width of PC and all address ports.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset, truncated to DATA_WIDTH.
- START_HALTED, 0: if 1, the unit leaves reset in HALT instead of RUN.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hazard stall; hold PC.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_target  in  DATA_WIDTH  branch/jump target address.
- redirect_is_jalr  in  1  target comes from JALR; bit 0 is cleared before use.
- trap  in  1  exception/interrupt taken.
- trap_vector  in  DATA_WIDTH  trap handler base; bits [1:0] are forced to 0.
- halt_req  in  1  debug halt request.
- resume  in  1  leave HALT.
- fetch_ready  in  1  instruction memory accepts the current PC.
- pc  out  DATA_WIDTH  current fetch address.
- pc_plus_inc  out  DATA_WIDTH  pc + increment, combinational, modulo 2^DATA_WIDTH.
- pc_valid  out  1  pc is a valid fetch request.
- misaligned  out  1  one-cycle pulse: a redirect was rejected as misaligned.
- misaligned_addr  out  DATA_WIDTH  offending target, held until the next rejection.
- halted  out  1  unit is in HALT.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_VECTOR, misaligned=0, misaligned_addr=0.
  - State=BOOT, pc_valid=0, halted=0.
- States: BOOT, RUN, HALT.
  - BOOT: exactly one cycle after rst deasserts, pc_valid=0. Goes to HALT if START_HALTED=1, else to RUN. No PC change in BOOT.
  - RUN: pc_valid=1.
    - If halt_req=1, go to HALT next cycle. A PC update in the same cycle still applies.
  - HALT: pc_valid=0, halted=1, PC frozen.
    - resume=1 returns to RUN next cycle.
    - trap=1 in HALT loads the vector but stays in HALT.
    - halt_req and resume both 1: halt_req wins (stay in/enter HALT).
- Next-PC selection in RUN, evaluated every cycle in this priority order:
  1. trap=1: pc <= {trap_vector[DW-1:2],2'b00}. Ignores stall and fetch_ready; the redirect is discarded.
  2. redirect_valid=1: target T = redirect_target, with bit 0 cleared if redirect_is_jalr.
     - If T is misaligned: pc holds, misaligned=1 next cycle, misaligned_addr<=T.
     - Otherwise pc <= T. Ignores stall and fetch_ready (flush semantics).
  3. stall=1 or fetch_ready=0: pc holds.
  4. Otherwise pc <= pc + 4, wrapping modulo 2^DATA_WIDTH (e.g. 32'hFFFF_FFFC -> 32'h0).
- Alignment: T is misaligned if T[1:0] != 0.
- Latency: one cycle from any input event to the pc change; pc_plus_inc is combinational from pc.
- misaligned is a registered pulse lasting one cycle. Back-to-back rejections give consecutive pulses, with misaligned_addr updated each time.
- Asserting rst mid-operation aborts immediately: all outputs take their reset values asynchronously.

Optional Feature:
- Macro: PC_UNIT_C_EXT_EN.
- Defined:
  - Adds port inst_is_compressed (in, 1).
  - Sequential increment is 2 when inst_is_compressed=1, else 4; pc_plus_inc follows the same rule.
  - Alignment check uses T[0] only, so a target with T[1:0]=2'b10 is legal.
  - trap_vector is still forced to 4-byte alignment.
- Undefined: the port is absent, the increment is always 4, and the alignment check uses T[1:0].

Test Plan (DATA_WIDTH=32, RESET_VECTOR=0, START_HALTED=0):
- Reset then run: rst for 2 cycles, release, fetch_ready=1 -> BOOT with pc_valid=0 for 1 cycle, then pc sequence 0x0,0x4,0x8,0xC with pc_valid=1.
- Stall and handshake: pc=0x10, stall=1 for 3 cycles, then fetch_ready=0 for 2 cycles -> pc holds at 0x10 throughout; next cycle 0x14.
- Redirect priority: stall=1, redirect_valid=1, target 0x200 -> pc=0x200 next cycle. In the same cycle as trap=1 with trap_vector=0x80000103 and redirect 0x300 -> pc=0x80000100.
- Misaligned JALR vs branch: redirect_is_jalr=1 with target 0x1001 -> pc=0x1000 (bit 0 cleared, then aligned), no pulse. redirect_is_jalr=0 with target 0x1002 -> pc holds, misaligned pulses for 1 cycle, misaligned_addr=0x1002.
- Halt/resume plus wrap: pc=0xFFFFFFFC, halt_req=1 -> pc=0x0 (update applies), then HALT with halted=1 and pc_valid=0, pc frozen at 0x0 for 5 cycles. resume=1 -> RUN, pc continues 0x4.
- Async reset mid-run and C extension: assert rst between clock edges at pc=0x40 -> pc=0 immediately. With PC_UNIT_C_EXT_EN, inst_is_compressed pattern 1,0,1 from pc=0 -> 0x2,0x6,0x8. A branch to 0x1002 is accepted without a misaligned pulse.
